ysyx_23060170_shift_pipe: RTL
=============================

YSYX_23060170_SHIFT_PIPE -- requirements
Module: ysyx_23060170_shift_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 4, meaning width of the sideband tag carried alongside each operation.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high at a rising edge.
REQ-007 SHALL have port in_src  input  XLEN  operand to shift.
REQ-008 SHALL have port in_amt  input  log2(XLEN)  shift amount.
REQ-009 SHALL have port in_op  input  3  operation code: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 illegal.
REQ-010 SHALL have port in_word  input  1  32-bit word mode (RV64 *W); ignored when XLEN=32.
REQ-011 SHALL have port in_tag  input  TAG_W  opaque tag.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result when out_valid and out_ready are both high at a rising edge.
REQ-014 SHALL have port out_res  output  XLEN  shift result.
REQ-015 SHALL have port out_tag  output  TAG_W  tag of the result.
REQ-016 SHALL have port out_err  output  1  high when the result came from an illegal op.

Function
REQ-017 SHALL implement a two-stage pipeline, S1 and S2, each holding a valid bit; S2 drives the out_* ports.
REQ-018 SHALL present a result accepted at edge N on out_* from edge N+2, provided no stall occurs; latency is 2 cycles.
REQ-019 SHALL sustain one operation per cycle when out_ready is held high.
REQ-020 SHALL advance S1 to S2 when S1 is valid and (S2 is empty or out_ready is high).
REQ-021 SHALL drive in_ready = !S1.valid || S1-advance, combinationally; it must not depend on in_valid.
REQ-022 SHALL hold S2 contents stable while out_valid is high and out_ready is low.
REQ-023 SHALL deliver results in acceptance order, with no drop and no duplication under any in_valid/out_ready pattern.
REQ-024 SHALL in S1 perform the coarse shift, by in_amt upper bits in multiples of 8; S2 performs the fine shift, by in_amt[2:0], plus result merge.
REQ-025 SHALL use amount = in_amt[4:0] when in_word is high, otherwise full in_amt.
REQ-026 SHALL compute SLL/SRL as logical shifts with zero fill.
REQ-027 SHALL compute SRA with fill from the operand MSB: bit XLEN-1, or bit 31 in word mode.
REQ-028 SHALL compute ROL/ROR as rotation within XLEN bits, or within 32 bits in word mode.
REQ-029 SHALL in word mode operate on in_src[31:0] and sign-extend bit 31 of the 32-bit result to XLEN.
REQ-030 SHALL for amount 0 return the operand unchanged (word mode: sign-extended low word).
REQ-031 SHALL for an illegal op return out_res = 0 and out_err = 1; otherwise out_err = 0.
REQ-032 SHALL pass in_tag to out_tag unmodified.

Reset
REQ-033 SHALL on reset clear S1.valid and S2.valid; out_valid=0, out_res=0, out_tag=0, out_err=0, in_ready=1 in the cycle after reset deasserts.
REQ-034 SHALL discard in-flight operations when reset is asserted mid-operation; none emerge afterwards.
REQ-035 SHALL ignore in_valid during reset; no request is accepted while reset is high.

Verification
REQ-036 SHALL be verified with XLEN=64, SRA, src=0x8000_0000_0000_0000, amt=4 -> out_res=0xF800_0000_0000_0000, out_valid two cycles after acceptance.
REQ-037 SHALL be verified with SLL, word=1, src=0x0000_0000_4000_0001, amt=1 -> 0xFFFF_FFFF_8000_0002; SRA word, src=0x8000_0000, amt=31 -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-038 SHALL be verified with ROR, src=0x1, amt=1 -> 0x8000_0000_0000_0000; ROL word, src=0x8000_0001, amt=1 -> 0x0000_0000_0000_0003; op=110 -> out_res=0, out_err=1.
REQ-039 SHALL be verified with 4 back-to-back requests tagged 0-3 and out_ready low for 3 cycles -> in_ready falls after 2 accepted, out_res/out_tag hold stable, then tags 0,1,2,3 emerge in order with no bubbles once out_ready rises.
REQ-040 SHALL be verified with reset asserted one cycle after accepting 2 requests -> out_valid=0 after reset, no stale result appears, in_ready=1.
REQ-041 SHALL be verified with a randomized stream of 10k ops (random in_valid/out_ready) against a reference model -> all results and tags match in order.

Source files
------------

// File: rtl/ysyx_23060170_shift_pipe_if.sv
// Request/result bundle for the two-stage shift pipeline.
// The master side issues requests and consumes results; the slave side is the pipeline.
interface ysyx_23060170_shift_pipe_if #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 4
);
   localparam int AMT_W = $clog2(XLEN);

   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  in_src;
   logic [AMT_W-1:0] in_amt;
   logic [2:0]       in_op;
   logic             in_word;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_res;
   logic [TAG_W-1:0] out_tag;
   logic             out_err;

   modport master (
      output in_valid, in_src, in_amt, in_op, in_word, in_tag, out_ready,
      input  in_ready, out_valid, out_res, out_tag, out_err
   );

   modport slave (
      input  in_valid, in_src, in_amt, in_op, in_word, in_tag, out_ready,
      output in_ready, out_valid, out_res, out_tag, out_err
   );
endinterface

// File: rtl/ysyx_23060170_shift_pipe.sv
// Two-stage shifter: S1 shifts by whole bytes, S2 finishes the 0..7 bit shift,
// applies word-mode sign extension and drives the result handshake.
module ysyx_23060170_shift_pipe #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 4
) (
   input logic                        clock,
   input logic                        reset,
   ysyx_23060170_shift_pipe_if.slave  bus
);
   localparam int AMT_W = $clog2(XLEN);
   localparam logic [AMT_W:0] XLEN_V = (AMT_W + 1)'(XLEN);

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   // Shifts compose, so the same operator serves both the byte and the bit stage.
   // A rotate by zero relies on x >> XLEN evaluating to zero.
   function automatic logic [XLEN-1:0] shift_op(input logic [2:0] op,
                                                input logic [XLEN-1:0] x,
                                                input logic [AMT_W-1:0] k);
      logic [AMT_W:0] rk;
      rk = XLEN_V - {1'b0, k};
      case (op)
         OP_SLL:  shift_op = x << k;
         OP_SRL:  shift_op = x >> k;
         OP_SRA:  shift_op = $unsigned($signed(x) >>> k);
         OP_ROL:  shift_op = (x << k) | (x >> rk);
         OP_ROR:  shift_op = (x >> k) | (x << rk);
         default: shift_op = '0;
      endcase
   endfunction

   logic             in_fire;
   logic             s1_adv;
   logic             in_ready_w;
   logic             word_eff;
   logic [AMT_W-1:0] amt_eff;
   logic [XLEN-1:0]  opnd;
   logic [XLEN-1:0]  coarse;
   logic [XLEN-1:0]  s2_fine;
   logic [XLEN-1:0]  s2_res;

   logic             s1_valid_q, s1_valid_d;
   logic [XLEN-1:0]  s1_data_q,  s1_data_d;
   logic [2:0]       s1_fine_q,  s1_fine_d;
   logic [2:0]       s1_op_q,    s1_op_d;
   logic             s1_word_q,  s1_word_d;
   logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
   logic             s1_err_q,   s1_err_d;

   logic             s2_valid_q, s2_valid_d;
   logic [XLEN-1:0]  s2_res_q,   s2_res_d;
   logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
   logic             s2_err_q,   s2_err_d;

   assign s1_adv     = s1_valid_q && (!s2_valid_q || bus.out_ready);
   assign in_ready_w = !s1_valid_q || s1_adv;
   assign in_fire    = bus.in_valid && in_ready_w;

   // Word mode widens the low word so an XLEN-wide shift yields the 32-bit answer
   // in bits [31:0]: sign-extend for SRA, duplicate for rotates, zero-extend otherwise.
   generate
      if (XLEN == 64) begin : g_rv64
         logic [31:0] lo;
         assign lo       = bus.in_src[31:0];
         assign word_eff = bus.in_word;
         assign amt_eff  = bus.in_word ? {1'b0, bus.in_amt[4:0]} : bus.in_amt;

         always_comb begin
            opnd = bus.in_src;
            if (bus.in_word) begin
               case (bus.in_op)
                  OP_SRA:         opnd = {{32{lo[31]}}, lo};
                  OP_ROL, OP_ROR: opnd = {lo, lo};
                  default:        opnd = {32'b0, lo};
               endcase
            end
         end

         assign s2_res = s1_err_q  ? '0 :
                         s1_word_q ? {{32{s2_fine[31]}}, s2_fine[31:0]} : s2_fine;
      end else begin : g_rv32
         assign word_eff = 1'b0;
         assign amt_eff  = bus.in_amt;
         assign opnd     = bus.in_src;
         assign s2_res   = s1_err_q ? '0 : s2_fine;
      end
   endgenerate

   assign coarse  = shift_op(bus.in_op, opnd, {amt_eff[AMT_W-1:3], 3'b000});
   assign s2_fine = shift_op(s1_op_q, s1_data_q, {{(AMT_W-3){1'b0}}, s1_fine_q});

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_fine_d  = s1_fine_q;
      s1_op_d    = s1_op_q;
      s1_word_d  = s1_word_q;
      s1_tag_d   = s1_tag_q;
      s1_err_d   = s1_err_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_data_d  = coarse;
         s1_fine_d  = amt_eff[2:0];
         s1_op_d    = bus.in_op;
         s1_word_d  = word_eff;
         s1_tag_d   = bus.in_tag;
         s1_err_d   = (bus.in_op > OP_ROR);
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
   end

   // S2 data is only rewritten on an advance, which keeps it frozen under backpressure.
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_res_d   = s2_res_q;
      s2_tag_d   = s2_tag_q;
      s2_err_d   = s2_err_q;
      if (s1_adv) begin
         s2_valid_d = 1'b1;
         s2_res_d   = s2_res;
         s2_tag_d   = s1_tag_q;
         s2_err_d   = s1_err_q;
      end else if (bus.out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_fine_q  <= '0;
         s1_op_q    <= '0;
         s1_word_q  <= 1'b0;
         s1_tag_q   <= '0;
         s1_err_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_tag_q   <= '0;
         s2_err_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_fine_q  <= s1_fine_d;
         s1_op_q    <= s1_op_d;
         s1_word_q  <= s1_word_d;
         s1_tag_q   <= s1_tag_d;
         s1_err_q   <= s1_err_d;
         s2_valid_q <= s2_valid_d;
         s2_res_q   <= s2_res_d;
         s2_tag_q   <= s2_tag_d;
         s2_err_q   <= s2_err_d;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_res   = s2_res_q;
   assign bus.out_tag   = s2_tag_q;
   assign bus.out_err   = s2_err_q;
endmodule
